// File: rtl/merge_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : merge_seq_ctrl
// Description : Iterative CORDIC merge-stage sequencer. It shares one
//               shift/negate unit and one adder across iterations K_FIRST..,
//               and presents the result through a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module merge_seq_ctrl #(
    parameter int WIDTH   = 22,
    parameter int K_FIRST = 9,
    parameter int N_ITER  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  x_in,
    input  logic [WIDTH-1:0]  z_in,
    input  logic [N_ITER-1:0] dir_in,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  z_out
);

    localparam int c_K_MAX = (K_FIRST + N_ITER > WIDTH) ? (K_FIRST + N_ITER) : WIDTH;
    localparam int c_KW    = $clog2(c_K_MAX + 1);
    localparam int c_IW    = (N_ITER > 1) ? $clog2(N_ITER) : 1;

    localparam logic [c_KW-1:0] c_K_FIRST     = c_KW'(K_FIRST);
    localparam logic [c_KW-1:0] c_SHIFT_LIMIT = c_KW'(WIDTH);
    localparam logic [c_IW-1:0] c_LAST_I      = c_IW'(N_ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_x;
    logic [WIDTH-1:0]  r_acc;
    logic [N_ITER-1:0] r_dir;
    logic [c_KW-1:0]   r_k;
    logic [c_IW-1:0]   r_i;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_z_out;

    logic [WIDTH-1:0]  w_t;
    logic [WIDTH-1:0]  w_term;
    logic [WIDTH-1:0]  w_sum;
    logic              w_dir_bit;
    logic              w_last;

    // Shifts at or beyond the datapath width contribute nothing, for either sign.
    always_comb begin
        w_t       = (r_k >= c_SHIFT_LIMIT) ? '0 : (r_x >> r_k);
        w_dir_bit = r_dir[r_i];
        w_term    = w_dir_bit ? w_t : (~w_t + WIDTH'(1));
        w_sum     = r_acc + w_term;
        w_last    = (r_i == c_LAST_I);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_acc       <= '0;
            r_dir       <= '0;
            r_k         <= '0;
            r_i         <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_z_out     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x        <= x_in;
                        r_acc      <= z_in;
                        r_dir      <= dir_in;
                        r_k        <= c_K_FIRST;
                        r_i        <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_sum;
                    r_k   <= r_k + c_KW'(1);
                    r_i   <= r_i + c_IW'(1);
                    if (w_last) begin
                        r_z_out     <= w_sum;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign z_out     = r_z_out;

endmodule
`default_nettype wire

// File: tb/tb_merge_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_merge_seq_ctrl
// Description : Directed and randomized bench for merge_seq_ctrl against an
//               arithmetic reference of the merge sum.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_merge_seq_ctrl;

    localparam int WIDTH   = 22;
    localparam int K_FIRST = 9;
    localparam int N_ITER  = 8;

    logic              clk;
    logic              rst;
    logic              start;
    logic              in_ready;
    logic [WIDTH-1:0]  x_in;
    logic [WIDTH-1:0]  z_in;
    logic [N_ITER-1:0] dir_in;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  z_out;

    int checks   = 0;
    int failures = 0;

    merge_seq_ctrl #(.WIDTH(WIDTH), .K_FIRST(K_FIRST), .N_ITER(N_ITER)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .z_in      (z_in),
        .dir_in    (dir_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z_out     (z_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // Result = z + sum over i of (+/-)(x >> (K_FIRST+i)), taken modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] z,
                                               input logic [N_ITER-1:0] d);
        longint acc;
        longint t;
        int     k;
        acc = longint'(z);
        for (int i = 0; i < N_ITER; i++) begin
            k = K_FIRST + i;
            t = (k >= WIDTH) ? 64'sd0 : (longint'(x) >>> k);
            acc = d[i] ? (acc + t) : (acc - t);
        end
        return acc[WIDTH-1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full job: accept, N_ITER run edges, optional back-pressure, handshake.
    task automatic run_job(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] z,
                           input logic [N_ITER-1:0] d, input logic [WIDTH-1:0] exp,
                           input int stall, input bit noisy);
        check("idle_in_ready", 64'(in_ready), 64'd1);
        check("idle_out_valid", 64'(out_valid), 64'd0);
        x_in = x; z_in = z; dir_in = d; start = 1'b1;
        tick();
        x_in = WIDTH'($urandom); z_in = WIDTH'($urandom); dir_in = N_ITER'($urandom);
        start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        check("run_busy", 64'(busy), 64'd1);
        check("run_in_ready", 64'(in_ready), 64'd0);
        for (int n = 1; n < N_ITER; n++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (noisy) start = 1'b1;
            tick();
            check("run_no_valid", 64'(out_valid), 64'd0);
            check("run_busy_hold", 64'(busy), 64'd1);
        end
        out_ready = 1'($urandom_range(0, 1));
        tick();
        check("done_valid", 64'(out_valid), 64'd1);
        check("done_busy", 64'(busy), 64'd0);
        check("done_in_ready", 64'(in_ready), 64'd0);
        check("done_z_out", 64'(z_out), 64'(exp));
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            if (noisy) start = 1'b1;
            tick();
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_z_out", 64'(z_out), 64'(exp));
        end
        out_ready = 1'b1;
        if (noisy) start = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        check("hs_valid_low", 64'(out_valid), 64'd0);
        check("hs_in_ready", 64'(in_ready), 64'd1);
        check("hs_z_hold", 64'(z_out), 64'(exp));
    endtask

    initial begin
        logic [WIDTH-1:0]  rx;
        logic [WIDTH-1:0]  rz;
        logic [N_ITER-1:0] rd;

        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        x_in = '0; z_in = '0; dir_in = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_z_out", 64'(z_out), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_hold_ready", 64'(in_ready), 64'd1);
        check("idle_hold_busy", 64'(busy), 64'd0);

        run_job(22'h100000, 22'h000000, 8'hFF, 22'h000FF0, 0, 1'b0);
        run_job(22'h100000, 22'h000000, 8'h00, 22'h3FF010, 0, 1'b0);
        run_job(22'h100000, 22'h000010, 8'h55, 22'h000560, 1, 1'b0);
        run_job(22'h100000, 22'h3FFFFF, 8'hFF, 22'h000FEF, 0, 1'b0);
        run_job(22'h3FFFFF, 22'h0ABCDE, 8'hA3, model(22'h3FFFFF, 22'h0ABCDE, 8'hA3), 3, 1'b1);

        // Abort during the 4th RUN cycle.
        x_in = 22'h3FFFFF; z_in = 22'h155555; dir_in = 8'h0F; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("pre_abort_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_z_out", 64'(z_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_job(22'h000200, 22'h000000, 8'hFF, 22'h000001, 0, 1'b0);
        run_job(22'h100000, 22'h000010, 8'h55, 22'h000560, 0, 1'b0);

        for (int j = 0; j < 24; j++) begin
            rx = WIDTH'($urandom);
            rz = WIDTH'($urandom);
            rd = N_ITER'($urandom);
            run_job(rx, rz, rd, model(rx, rz, rd), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
